// File: rtl/sram_32x8_req_ctrl.sv
// Request/response front end for a single-port SRAM macro with a 2-deep read-response FIFO.
// Optional power-up zeroing of the array is enabled with `define SRAM_CTRL_ZERO_INIT_EN.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   INIT  | zeroing the array, one word per cycle, requests held off
//   RUN   | normal operation, terminal until reset
module sram_32x8_req_ctrl #(
    parameter int BITS       = 32,
    parameter int WORD_DEPTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,

    input  logic                  v_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [BITS-1:0]       data_i,
    input  logic [BITS-1:0]       mask_i,
    output logic                  ready_o,

    output logic                  v_o,
    output logic [BITS-1:0]       data_o,
    input  logic                  yumi_i,

    output logic                  sram_ce_o,
    output logic                  sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [BITS-1:0]       sram_wd_o,
    output logic [BITS-1:0]       sram_w_mask_o,
    input  logic [BITS-1:0]       sram_rd_i
);

    localparam logic [0:0] RUN = 1'b1;

    logic [0:0]      state_r;
    logic            accept;
    logic            rd_accept;
    logic            consume;
    logic            inflight_r;
    logic [1:0]      count_r;
    logic [1:0]      fifo_cnt_r;
    logic            fifo_wptr_r;
    logic            fifo_rptr_r;
    logic            fifo_empty;
    logic            enq;
    logic            deq;
    logic [BITS-1:0] fifo_mem [2];

`ifdef SRAM_CTRL_ZERO_INIT_EN
    localparam logic [0:0]            INIT      = 1'b0;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] init_left_r;
    logic                  init_active;
    logic [ADDR_WIDTH-1:0] init_addr;

    // Down-counter of words still to clear; address ascends as it drains.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r     <= INIT;
            init_left_r <= LAST_ADDR;
        end else if (state_r == INIT) begin
            if (init_left_r == '0) begin
                state_r <= RUN;
            end else begin
                init_left_r <= init_left_r - 1'b1;
            end
        end
    end

    assign init_active = reset_n_i & (state_r == INIT);
    assign init_addr   = LAST_ADDR - init_left_r;
`else
    assign state_r = RUN;
`endif

    // Occupancy counts the in-flight read too, so ready never needs yumi_i.
    assign ready_o    = reset_n_i & (state_r == RUN) & (count_r < 2'd2);
    assign accept     = v_i & ready_o;
    assign rd_accept  = accept & ~we_i;

    assign fifo_empty = (fifo_cnt_r == 2'd0);
    assign v_o        = reset_n_i & (~fifo_empty | inflight_r);
    assign data_o     = fifo_empty ? sram_rd_i : fifo_mem[fifo_rptr_r];
    assign consume    = yumi_i & v_o;

    // Read data skips the FIFO only when it is both empty and being drained.
    assign enq        = inflight_r & ~(fifo_empty & yumi_i);
    assign deq        = yumi_i & ~fifo_empty;

    always_comb begin
        sram_ce_o     = 1'b0;
        sram_we_o     = 1'b0;
        sram_addr_o   = '0;
        sram_wd_o     = '0;
        sram_w_mask_o = '0;
        if (accept) begin
            sram_ce_o     = 1'b1;
            sram_we_o     = we_i;
            sram_addr_o   = addr_i;
            sram_wd_o     = we_i ? data_i : '0;
            sram_w_mask_o = we_i ? mask_i : '0;
        end
`ifdef SRAM_CTRL_ZERO_INIT_EN
        else if (init_active) begin
            sram_ce_o     = 1'b1;
            sram_we_o     = 1'b1;
            sram_addr_o   = init_addr;
            sram_wd_o     = '0;
            sram_w_mask_o = '1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            inflight_r  <= 1'b0;
            count_r     <= 2'd0;
            fifo_cnt_r  <= 2'd0;
            fifo_wptr_r <= 1'b0;
            fifo_rptr_r <= 1'b0;
        end else begin
            inflight_r <= rd_accept;
            count_r    <= count_r + 2'(rd_accept) - 2'(consume);
            fifo_cnt_r <= fifo_cnt_r + 2'(enq) - 2'(deq);
            if (enq) begin
                fifo_wptr_r <= ~fifo_wptr_r;
            end
            if (deq) begin
                fifo_rptr_r <= ~fifo_rptr_r;
            end
        end
    end

    // Storage needs no reset; validity is tracked by fifo_cnt_r.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && enq) begin
            fifo_mem[fifo_wptr_r] <= sram_rd_i;
        end
    end

    a_yumi_needs_valid : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi_i |-> v_o)
        else $error("yumi_i asserted with no response valid");

    a_count_bound : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        count_r <= 2'd2)
        else $error("response occupancy exceeded two");

endmodule

// File: tb/tb_sram_32x8_req_ctrl.sv
// Directed bench for sram_32x8_req_ctrl with a behavioural 32x32 masked-write SRAM.
// Build with +define+SRAM_CTRL_ZERO_INIT_EN to also exercise the zeroing sequence.
module tb_sram_32x8_req_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i;
    logic        we_i;
    logic [4:0]  addr_i;
    logic [31:0] data_i;
    logic [31:0] mask_i;
    logic        ready_o;
    logic        v_o;
    logic [31:0] data_o;
    logic        yumi_i;
    logic        sram_ce_o;
    logic        sram_we_o;
    logic [4:0]  sram_addr_o;
    logic [31:0] sram_wd_o;
    logic [31:0] sram_w_mask_o;
    logic [31:0] sram_rd_i;

    logic [31:0] sram_mem [32];

    int checks   = 0;
    int failures = 0;

`ifdef SRAM_CTRL_ZERO_INIT_EN
    localparam logic [31:0] EXP_AFTER_RESET = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_AFTER_RESET = 32'hDEAD_BEEF;
`endif

    always #5 clk_i = ~clk_i;

    sram_32x8_req_ctrl #(
        .BITS       (32),
        .WORD_DEPTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .v_i           (v_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .data_i        (data_i),
        .mask_i        (mask_i),
        .ready_o       (ready_o),
        .v_o           (v_o),
        .data_o        (data_o),
        .yumi_i        (yumi_i),
        .sram_ce_o     (sram_ce_o),
        .sram_we_o     (sram_we_o),
        .sram_addr_o   (sram_addr_o),
        .sram_wd_o     (sram_wd_o),
        .sram_w_mask_o (sram_w_mask_o),
        .sram_rd_i     (sram_rd_i)
    );

    // Macro model: masked write, read data registered one cycle after the strobe.
    always @(posedge clk_i) begin
        if (sram_ce_o) begin
            if (sram_we_o) begin
                sram_mem[sram_addr_o] <= (sram_mem[sram_addr_o] & ~sram_w_mask_o)
                                       | (sram_wd_o & sram_w_mask_o);
            end else begin
                sram_rd_i <= sram_mem[sram_addr_o];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] m, input logic y);
        v_i    = v;
        we_i   = we;
        addr_i = a;
        data_i = d;
        mask_i = m;
        yumi_i = y;
        #1;
    endtask

    task automatic write_word(input logic [4:0] a, input logic [31:0] d, input logic [31:0] m);
        tick();
        drive(1'b1, 1'b1, a, d, m, 1'b0);
        check("wr_ready", 32'(ready_o), 32'd1);
    endtask

    task automatic wait_init();
`ifdef SRAM_CTRL_ZERO_INIT_EN
        for (int k = 0; k < 32; k++) tick();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        sram_rd_i = 32'h0;
        reset_n_i = 1'b0;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_v_o", 32'(v_o), 32'd0);
        check("rst_ce", 32'(sram_ce_o), 32'd0);
        tick();
        tick();
        check("rst_ready_held", 32'(ready_o), 32'd0);

        tick();
        reset_n_i = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
`ifdef SRAM_CTRL_ZERO_INIT_EN
        for (int k = 0; k < 32; k++) begin
            check("init_ready", 32'(ready_o), 32'd0);
            check("init_addr", 32'(sram_addr_o), 32'(k));
            check("init_we", 32'(sram_we_o), 32'd1);
            check("init_mask", sram_w_mask_o, 32'hFFFF_FFFF);
            tick();
            #1;
        end
        check("init_done_ready", 32'(ready_o), 32'd1);
        drive(1'b1, 1'b0, 5'd31, 32'h0, 32'h0, 1'b0);
        check("init_rd31_ce", 32'(sram_ce_o), 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        check("init_rd31_v", 32'(v_o), 32'd1);
        check("init_rd31_data", data_o, 32'h0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
`endif
        check("run_ready", 32'(ready_o), 32'd1);

        // Write addr 3 and inspect the macro-side strobes.
        tick();
        drive(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);
        check("w3_ce", 32'(sram_ce_o), 32'd1);
        check("w3_we", 32'(sram_we_o), 32'd1);
        check("w3_addr", 32'(sram_addr_o), 32'd3);
        check("w3_wd", sram_wd_o, 32'hDEAD_BEEF);
        check("w3_mask", sram_w_mask_o, 32'hFFFF_FFFF);

        write_word(5'd1, 32'h1111_1111, 32'hFFFF_FFFF);
        write_word(5'd2, 32'h2222_2222, 32'hFFFF_FFFF);
        for (int i = 16; i < 32; i++) write_word(5'(i), 32'hA500_0000 | 32'(i), 32'hFFFF_FFFF);
        write_word(5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        write_word(5'd7, 32'h0000_0000, 32'h0000_FF00);

        tick();
        drive(1'b1, 1'b0, 5'd3, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
        check("r3_ce", 32'(sram_ce_o), 32'd1);
        check("r3_we", 32'(sram_we_o), 32'd0);
        check("r3_wd_zero", sram_wd_o, 32'h0);
        check("r3_mask_zero", sram_w_mask_o, 32'h0);
        check("no_wr_resp", 32'(v_o), 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        check("r3_v", 32'(v_o), 32'd1);
        check("r3_data", data_o, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        check("r3_done", 32'(v_o), 32'd0);

        tick();
        drive(1'b1, 1'b0, 5'd7, 32'h0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        check("r7_data", data_o, 32'hFFFF_00FF);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);

        // Backpressure: third read stalls until the consumer drains.
        tick();
        drive(1'b1, 1'b0, 5'd1, 32'h0, 32'h0, 1'b0);
        check("bp_a_ready", 32'(ready_o), 32'd1);
        tick();
        drive(1'b1, 1'b0, 5'd2, 32'h0, 32'h0, 1'b0);
        check("bp_b_ready", 32'(ready_o), 32'd1);
        check("bp_b_v", 32'(v_o), 32'd1);
        check("bp_b_data", data_o, 32'h1111_1111);
        tick();
        drive(1'b1, 1'b0, 5'd3, 32'h0, 32'h0, 1'b0);
        check("bp_c_ready", 32'(ready_o), 32'd0);
        check("bp_c_ce", 32'(sram_ce_o), 32'd0);
        check("bp_c_data", data_o, 32'h1111_1111);
        tick();
        drive(1'b1, 1'b0, 5'd3, 32'h0, 32'h0, 1'b1);
        check("bp_d_ready", 32'(ready_o), 32'd0);
        check("bp_d_data", data_o, 32'h1111_1111);
        tick();
        drive(1'b1, 1'b0, 5'd3, 32'h0, 32'h0, 1'b1);
        check("bp_e_ready", 32'(ready_o), 32'd1);
        check("bp_e_ce", 32'(sram_ce_o), 32'd1);
        check("bp_e_data", data_o, 32'h2222_2222);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        check("bp_f_v", 32'(v_o), 32'd1);
        check("bp_f_data", data_o, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        check("bp_g_v", 32'(v_o), 32'd0);

        // Streaming reads with the consumer always ready.
        for (int i = 0; i < 16; i++) begin
            tick();
            drive(1'b1, 1'b0, 5'(16 + i), 32'h0, 32'h0, i > 0);
            check("str_ready", 32'(ready_o), 32'd1);
            if (i > 0) begin
                check("str_v", 32'(v_o), 32'd1);
                check("str_data", data_o, 32'hA500_0000 | 32'(15 + i));
            end
        end
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        check("str_last_data", data_o, 32'hA500_001F);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        check("str_done", 32'(v_o), 32'd0);

        // Reset with one FIFO entry and one read in flight.
        tick();
        drive(1'b1, 1'b0, 5'd1, 32'h0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 5'd2, 32'h0, 32'h0, 1'b0);
        tick();
        reset_n_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        check("mid_rst_v", 32'(v_o), 32'd0);
        check("mid_rst_ready", 32'(ready_o), 32'd0);
        tick();
        reset_n_i = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        check("post_rst_v", 32'(v_o), 32'd0);
        tick();
        check("post_rst_v2", 32'(v_o), 32'd0);
        wait_init();
        tick();
        drive(1'b1, 1'b0, 5'd3, 32'h0, 32'h0, 1'b0);
        check("post_rst_ready", 32'(ready_o), 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        check("post_rst_rd_v", 32'(v_o), 32'd1);
        check("post_rst_rd_data", data_o, EXP_AFTER_RESET);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        check("post_rst_idle", 32'(v_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
